// File: rtl/arrow_lane_engine.sv
// Note engine for the dance-pad game: per-lane scrolling arrow slots, press judging
// (hit/miss/stray), score and combo tracking, and a registered "arrow here" pixel query.
module arrow_lane_engine #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TICK_DIV   = 500000,
  parameter int unsigned START_Y    = 408,
  parameter int unsigned HIT_WIN    = 16,
  parameter int unsigned TOP_Y      = 36,
  parameter int unsigned LANE_X0    = 146,
  parameter int unsigned LANE_PITCH = 92,
  parameter int unsigned ARROW_W    = 72,
  localparam int unsigned LW        = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int unsigned CW        = $clog2(TICK_DIV)
) (
  input  logic             clk,
  input  logic             iRST_N,
  input  logic             run,
  input  logic             clear,
  input  logic [LANES-1:0] spawn_req,
  input  logic [LANES-1:0] pad_n,
  input  logic [10:0]      pix_x,
  input  logic [10:0]      pix_y,
  output logic             px_on,
  output logic [LW-1:0]    px_lane,
  output logic [LANES-1:0] hit,
  output logic [LANES-1:0] miss,
  output logic [LANES-1:0] stray,
  output logic [LANES-1:0] spawn_drop,
  output logic [15:0]      score,
  output logic [15:0]      combo,
  output logic [15:0]      max_combo
);

  localparam int unsigned SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tick;

  logic [LANES-1:0] sync1_q, sync2_q, prev_q;
  logic [LANES-1:0] press;

  logic             valid_q [LANES][DEPTH];
  logic             valid_d [LANES][DEPTH];
  logic [8:0]       dy_q    [LANES][DEPTH];
  logic [8:0]       dy_d    [LANES][DEPTH];

  logic [LANES-1:0] best_found;
  logic [SW-1:0]    best_idx [LANES];
  logic [8:0]       best_dy  [LANES];
  logic [LANES-1:0] free_found;
  logic [SW-1:0]    free_idx [LANES];

  logic [LANES-1:0] hit_q, hit_d;
  logic [LANES-1:0] miss_q, miss_d;
  logic [LANES-1:0] stray_q, stray_d;
  logic [LANES-1:0] drop_q, drop_d;

  logic [15:0]      score_q, score_d;
  logic [15:0]      combo_q, combo_d;
  logic [15:0]      max_q, max_d;
  logic [16:0]      nhits, score_sum, combo_sum;

  logic             px_on_q, px_on_d;
  logic [LW-1:0]    px_lane_q, px_lane_d;
  logic [10:0]      lane_x0, box_y0;
  logic             in_x, lane_match;

  // Scroll tick divider
  assign tick = run && (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Press is a falling edge of the synchronised pad level
  assign press = prev_q & ~sync2_q & {LANES{run}};

  // Per-lane slot selection: nearest valid arrow and lowest free slot
  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      best_found[l] = 1'b0;
      best_idx[l]   = '0;
      best_dy[l]    = '1;
      free_found[l] = 1'b0;
      free_idx[l]   = '0;
      for (int s = 0; s < int'(DEPTH); s++) begin
        if (valid_q[l][s] && (!best_found[l] || dy_q[l][s] < best_dy[l])) begin
          best_found[l] = 1'b1;
          best_idx[l]   = SW'(s);
          best_dy[l]    = dy_q[l][s];
        end
      end
      for (int s = int'(DEPTH) - 1; s >= 0; s--) begin
        if (!valid_q[l][s]) begin
          free_found[l] = 1'b1;
          free_idx[l]   = SW'(s);
        end
      end
    end
  end

  // Slot next state: judge on pre-tick dy, then scroll, then spawn into a slot free at cycle start
  always_comb begin
    valid_d = valid_q;
    dy_d    = dy_q;
    hit_d   = '0;
    miss_d  = '0;
    stray_d = '0;
    drop_d  = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      if (press[l]) begin
        if (best_found[l] && ({23'd0, best_dy[l]} <= HIT_WIN)) begin
          hit_d[l]                 = 1'b1;
          valid_d[l][best_idx[l]] = 1'b0;
        end else begin
          stray_d[l] = 1'b1;
        end
      end
      if (tick) begin
        for (int s = 0; s < int'(DEPTH); s++) begin
          if (valid_q[l][s] && !(hit_d[l] && best_idx[l] == SW'(s))) begin
            if (dy_q[l][s] == 9'd0) begin
              valid_d[l][s] = 1'b0;
              miss_d[l]     = 1'b1;
            end else begin
              dy_d[l][s] = dy_q[l][s] - 9'd1;
            end
          end
        end
      end
      if (run && spawn_req[l]) begin
        if (free_found[l]) begin
          valid_d[l][free_idx[l]] = 1'b1;
          dy_d[l][free_idx[l]]    = 9'(START_Y);
        end else begin
          drop_d[l] = 1'b1;
        end
      end
    end
    if (clear) begin
      for (int l = 0; l < int'(LANES); l++) begin
        for (int s = 0; s < int'(DEPTH); s++) begin
          valid_d[l][s] = 1'b0;
        end
      end
      hit_d   = '0;
      miss_d  = '0;
      stray_d = '0;
      drop_d  = '0;
    end
  end

  // Score and combo; any miss or stray this cycle outranks hits for the combo
  always_comb begin
    nhits = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      nhits = nhits + 17'(hit_d[l]);
    end
    score_sum = {1'b0, score_q} + nhits;
    combo_sum = {1'b0, combo_q} + nhits;
    score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    if ((|miss_d) || (|stray_d)) begin
      combo_d = '0;
    end else begin
      combo_d = combo_sum[16] ? 16'hFFFF : combo_sum[15:0];
    end
    max_d = (combo_d > max_q) ? combo_d : max_q;
    if (clear) begin
      score_d = '0;
      combo_d = '0;
      max_d   = '0;
    end
  end

  // Pixel query on current slot state; descending scan leaves the lowest matching lane
  always_comb begin
    px_on_d    = 1'b0;
    px_lane_d  = '0;
    lane_x0    = '0;
    box_y0     = '0;
    in_x       = 1'b0;
    lane_match = 1'b0;
    for (int l = int'(LANES) - 1; l >= 0; l--) begin
      lane_x0    = 11'(LANE_X0 + l * LANE_PITCH);
      in_x       = (pix_x >= lane_x0) && (pix_x <= lane_x0 + 11'(ARROW_W - 1));
      lane_match = 1'b0;
      for (int s = 0; s < int'(DEPTH); s++) begin
        box_y0 = 11'(TOP_Y) + 11'(dy_q[l][s]);
        if (valid_q[l][s] && in_x && (pix_y >= box_y0) &&
            (pix_y <= box_y0 + 11'(ARROW_W - 1))) begin
          lane_match = 1'b1;
        end
      end
      if (lane_match) begin
        px_on_d   = 1'b1;
        px_lane_d = LW'(l);
      end
    end
  end

  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt_q     <= '0;
      sync1_q   <= '1;
      sync2_q   <= '1;
      prev_q    <= '1;
      for (int l = 0; l < int'(LANES); l++) begin
        for (int s = 0; s < int'(DEPTH); s++) begin
          valid_q[l][s] <= 1'b0;
          dy_q[l][s]    <= '0;
        end
      end
      hit_q     <= '0;
      miss_q    <= '0;
      stray_q   <= '0;
      drop_q    <= '0;
      score_q   <= '0;
      combo_q   <= '0;
      max_q     <= '0;
      px_on_q   <= 1'b0;
      px_lane_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      sync1_q   <= pad_n;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      valid_q   <= valid_d;
      dy_q      <= dy_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      stray_q   <= stray_d;
      drop_q    <= drop_d;
      score_q   <= score_d;
      combo_q   <= combo_d;
      max_q     <= max_d;
      px_on_q   <= px_on_d;
      px_lane_q <= px_lane_d;
    end
  end

  assign hit        = hit_q;
  assign miss       = miss_q;
  assign stray      = stray_q;
  assign spawn_drop = drop_q;
  assign score      = score_q;
  assign combo      = combo_q;
  assign max_combo  = max_q;
  assign px_on      = px_on_q;
  assign px_lane    = px_lane_q;

endmodule
